// File: rtl/sipo_shift_register_4bit.sv
// 4-bit serial-in/parallel-out shift register. D enters Q[0] on every rising
// clk edge; the oldest bit falls off Q[3]. Asynchronous active-high reset clears it.
module sipo_shift_register_4bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       D,
  output logic [3:0] Q
);

  logic [3:0] shift_q;
  logic [3:0] shift_d;

  always_comb begin
    shift_d = {shift_q[2:0], D};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shift_q <= 4'b0000;
    else       shift_q <= shift_d;
  end

  // Q comes straight off the flops, so D never reaches it combinationally.
  assign Q = shift_q;

endmodule

// File: tb/tb_sipo_shift_register_4bit.sv
// Scoreboard bench: stimulus pushes the expected Q for each edge into a queue,
// a monitor pops and compares just after each rising edge.
`timescale 1ns/100ps
module tb_sipo_shift_register_4bit;

  logic       clk;
  logic       reset;
  logic       D;
  logic [3:0] Q;

  int checks   = 0;
  int failures = 0;

  bit         hist[$];     // serial bits shifted in since the last reset
  logic [3:0] exp_q[$];    // expected Q after each upcoming edge
  bit         stim_done = 0;

  sipo_shift_register_4bit dut (
    .clk  (clk),
    .reset(reset),
    .D    (D),
    .Q    (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Q holds the last four serial bits, newest at bit 0, zero-filled.
  function automatic logic [3:0] model_q();
    logic [3:0] r;
    int n;
    r = 4'b0000;
    n = hist.size();
    for (int i = 0; i < 4; i++)
      if (i < n) r[i] = hist[n-1-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive D/reset mid-cycle and predict Q after the next edge.
  task automatic step(input logic d, input logic r);
    @(negedge clk);
    D = d;
    reset = r;
    if (r) hist.delete();
    else   hist.push_back(d);
    exp_q.push_back(model_q());
  endtask

  // Monitor: compare on every edge for which a prediction was issued.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("edge_q", Q, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] held;
    logic [3:0] ps [7];
    logic       ds [7];
    ds = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ps = '{4'b0001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0100, 4'b1001};

    reset = 1'b1;
    D     = 1'b1;
    #1;
    chk("reset_initial", Q, 4'b0000);

    // Reset hold with D=1 over two edges
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    #7;
    chk("reset_hold_mid", Q, 4'b0000);

    // Shift pattern and drop-off, also checked against fixed values
    for (int i = 0; i < 7; i++) begin
      step(ds[i], 1'b0);
      @(posedge clk); #1;
      chk("pattern", Q, ps[i]);
    end

    // Fill then flush
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    @(posedge clk); #1;
    chk("fill_1111", Q, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    @(posedge clk); #1;
    chk("flush_0000", Q, 4'b0000);

    // Reach 1101, then async reset pulse between edges
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    @(posedge clk);
    #1.5 reset = 1'b1;
    #1.5 chk("async_reset_in_pulse", Q, 4'b0000);
    #1.5 reset = 1'b0;
    hist.delete();
    #0.2 chk("after_release_no_edge", Q, 4'b0000);
    step(1'b1, 1'b0);
    @(posedge clk); #1;
    chk("resume_0001", Q, 4'b0001);

    // D glitches between edges: Q must hold until the edge, then take 0
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    @(posedge clk); #1;
    held = model_q();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      D = ~D;
      #1;
      chk("glitch_hold", Q, held);
    end
    D = 1'b0;
    hist.push_back(1'b0);
    exp_q.push_back(model_q());
    @(posedge clk); #1;
    chk("glitch_shift0", Q, {held[2:0], 1'b0});

    // Randomized traffic with occasional synchronous-looking reset cycles
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    step(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    stim_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_shift_register_4bit.md
SIPO_SHIFT_REGISTER_4BIT -- requirements
Module: sipo_shift_register_4bit

Interface
REQ-001 Parameters: none; the register width is fixed at 4 bits.
REQ-002 clk  input  1  single clock for all state; rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset; clears the register.
REQ-004 D  input  1  serial data input, sampled on each rising edge of clk.
REQ-005 Q  output  4  parallel register contents; Q[0] is the newest bit, Q[3] the oldest.
REQ-006 The block SHALL use one clock (clk), and reset SHALL be asynchronous and active-high.

Function
REQ-007 The block SHALL contain exactly one 4-bit state register, and Q SHALL be driven directly from it with no combinational path from D to Q.
REQ-008 On each rising clk edge with reset low, the next state SHALL be {Q[2:0], D}:
  - D enters Q[0].
  - Q[i] moves to Q[i+1].
  - The old Q[3] is discarded.
REQ-009 Latency: a bit sampled at edge n SHALL appear on Q[0] after edge n, on Q[1] after n+1, on Q[2] after n+2, and on Q[3] after n+3.
REQ-010 After 4 consecutive shifts, Q SHALL equal the last 4 serial bits, with the first-shifted of those 4 in Q[3].
REQ-011 The register SHALL shift on every edge, with no enable or hold state; a constant D SHALL fill the register with that value after 4 edges.
REQ-012 Q SHALL change only on a rising clk edge or on reset assertion, never on D changes alone.
REQ-013 D SHALL be sampled at the clock edge; D changes between edges SHALL have no effect until the next edge.
REQ-014 The block SHALL contain no X-propagating logic: any D value of 0 or 1 SHALL produce deterministic Q.

Reset
REQ-015 When reset goes high, Q SHALL become 4'b0000 immediately, independent of clk.
REQ-016 While reset is high, Q SHALL stay 4'b0000 regardless of clk edges and D.
REQ-017 A rising clk edge at which reset is still high SHALL NOT shift.
REQ-018 The first shift SHALL occur on the first rising edge after reset is sampled low.
REQ-019 If reset is asserted mid-operation, the partial contents SHALL be lost, and shifting SHALL resume from 4'b0000 after deassertion.
REQ-020 The block SHALL have no power-on state requirement other than via reset.

Verification
Common bench setup:
  - 10 ns clk period.
  - D is changed mid-cycle, away from the rising edges.
  - Q is checked just after each rising edge.
REQ-021 Reset hold: reset=1 for 2 edges with D=1 -> Q=0000 at all times.
REQ-022 Shift pattern: after reset release, drive D=1,1,0,1 on successive edges -> Q=0001, 0011, 0110, 1101 after each edge.
REQ-023 Continue the REQ-022 sequence with D=0,0,1 -> Q=1010, 0100, 1001 (the oldest bit drops off Q[3]).
REQ-024 Fill/flush: D=1 for 4 edges -> Q=1111; then D=0 for 4 edges -> Q=1110, 1100, 1000, 0000.
REQ-025 Mid-operation async reset: with Q=1101, pulse reset high for 3 ns between edges -> Q=0000 within the pulse, before any clk edge. After release, with D=1, the next edge -> Q=0001.
REQ-026 D glitch immunity: toggle D several times between two edges, ending at D=0 before the edge. Q SHALL be unchanged until the edge, then shift in 0.
